// File: rtl/stopwatch_pkg.sv
// Shared types, moduli and helpers for the stopwatch: FSM state encoding,
// the display time bundle and the mod-N step function used by every counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    RUN_LAP = 2'd3
  } state_t;

  localparam int CS_MOD  = 100;
  localparam int SEC_MOD = 60;
  localparam int CS_W    = 7;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int STEP_W  = 8;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [CS_W-1:0]  cs;
  } time_t;

  // Prescaler and counters advance only while the watch is running.
  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == RUN_LAP);
  endfunction

  // Next value of a mod-N counter; the caller supplies "last" (val == N-1).
  function automatic logic [STEP_W-1:0] modn_step(input logic [STEP_W-1:0] val,
                                                  input logic              en,
                                                  input logic              last,
                                                  input logic              clr);
    logic [STEP_W-1:0] nxt;
    if (clr) begin
      nxt = {STEP_W{1'b0}};
    end else if (en && last) begin
      nxt = {STEP_W{1'b0}};
    end else if (en) begin
      nxt = val + 8'd1;
    end else begin
      nxt = val;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/modn_counter.sv
// Mod-N counter stage: advances on i_enable, clears synchronously on i_clear,
// and flags its terminal count combinationally so stages can cascade in one cycle.
module modn_counter
  import stopwatch_pkg::*;
#(
  parameter int N = 10
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 i_clear,
  input  logic                 i_enable,
  output logic [$clog2(N)-1:0] o_val,
  output logic                 o_last
);

  localparam int W = $clog2(N);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  assign o_last = (val_q == W'(N - 1));
  assign o_val  = val_q;

  always_comb begin
    val_d = W'(modn_step(STEP_W'(val_q), i_enable, o_last, i_clear));
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch top: run/pause/lap/clear FSM, prescaler, cs/sec/min cascade and a
// registered display that shows either the live time or the frozen lap time.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int MIN_MOD = 60
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             i_start_stop,
  input  logic             i_lap,
  input  logic             i_clear,
  output logic [CS_W-1:0]  o_cs,
  output logic [SEC_W-1:0] o_sec,
  output logic [MIN_W-1:0] o_min,
  output logic             o_running,
  output logic             o_lapped,
  output logic             o_overflow
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(PRESCALE);
  localparam int MW       = $clog2(MIN_MOD);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t state_q, state_d;

  logic [PW-1:0]    presc_q, presc_d;
  logic             counting_s, tick_s, start_s, clr_s;
  logic             en_cs_s, en_sec_s, en_min_s, wrap_s;
  logic [CS_W-1:0]  cs_val_s;
  logic [SEC_W-1:0] sec_val_s;
  logic [MW-1:0]    min_val_s;
  logic             cs_last_s, sec_last_s, min_last_s;

  time_t live_nx_s;
  time_t lap_q, lap_d;
  time_t disp_q, disp_d;
  logic  running_q, running_d;
  logic  lapped_q, lapped_d;
  logic  ovf_q, ovf_d;

  // FSM state register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start_stop outranks lap while running, clear outranks start_stop in PAUSE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start_stop) state_d = RUN;
        else              state_d = IDLE;
      end
      RUN: begin
        if (i_start_stop) state_d = PAUSE;
        else if (i_lap)   state_d = RUN_LAP;
        else              state_d = RUN;
      end
      RUN_LAP: begin
        if (i_start_stop) state_d = PAUSE;
        else if (i_lap)   state_d = RUN;
        else              state_d = RUN_LAP;
      end
      PAUSE: begin
        if (i_clear)           state_d = IDLE;
        else if (i_start_stop) state_d = RUN;
        else                   state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so the flags register with it
  always_comb begin
    running_d = is_counting(state_d);
    lapped_d  = (state_d == RUN_LAP);
  end

  // Tick generation and the enable cascade
  always_comb begin
    counting_s = is_counting(state_q);
    tick_s     = counting_s && (presc_q == PRESC_LAST);
    start_s    = (state_q == IDLE) && i_start_stop;
    clr_s      = (state_q == PAUSE) && i_clear;
    en_cs_s    = tick_s;
    en_sec_s   = tick_s && cs_last_s;
    en_min_s   = en_sec_s && sec_last_s;
    wrap_s     = en_min_s && min_last_s;
  end

  // Prescaler keeps its partial count across PAUSE; only start-from-idle and clear zero it
  always_comb begin
    if (start_s || clr_s) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else if (counting_s) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  modn_counter #(.N(CS_MOD)) u_cs (
    .clk      (clk),
    .areset_n (areset_n),
    .i_clear  (clr_s),
    .i_enable (en_cs_s),
    .o_val    (cs_val_s),
    .o_last   (cs_last_s)
  );

  modn_counter #(.N(SEC_MOD)) u_sec (
    .clk      (clk),
    .areset_n (areset_n),
    .i_clear  (clr_s),
    .i_enable (en_sec_s),
    .o_val    (sec_val_s),
    .o_last   (sec_last_s)
  );

  modn_counter #(.N(MIN_MOD)) u_min (
    .clk      (clk),
    .areset_n (areset_n),
    .i_clear  (clr_s),
    .i_enable (en_min_s),
    .o_val    (min_val_s),
    .o_last   (min_last_s)
  );

  // Live time after this edge; lap capture and display use it so a coincident tick is included
  always_comb begin
    live_nx_s.cs  = CS_W'(modn_step(STEP_W'(cs_val_s), en_cs_s, cs_last_s, clr_s));
    live_nx_s.sec = SEC_W'(modn_step(STEP_W'(sec_val_s), en_sec_s, sec_last_s, clr_s));
    live_nx_s.min = MIN_W'(modn_step(STEP_W'(min_val_s), en_min_s, min_last_s, clr_s));
  end

  // Lap latch, display mux and sticky overflow
  always_comb begin
    if ((state_q == RUN) && (state_d == RUN_LAP)) begin
      lap_d = live_nx_s;
    end else begin
      lap_d = lap_q;
    end

    if (lapped_d) begin
      disp_d = lap_d;
    end else begin
      disp_d = live_nx_s;
    end

    if (clr_s) begin
      ovf_d = 1'b0;
    end else if (wrap_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      presc_q   <= '0;
      lap_q     <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      lapped_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      lapped_q  <= lapped_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_cs       = disp_q.cs;
  assign o_sec      = disp_q.sec;
  assign o_min      = disp_q.min;
  assign o_running  = running_q;
  assign o_lapped   = lapped_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: two stopwatches (prescale 10 and prescale 2, both MIN_MOD=2)
// share stimulus; a tick-count model predicts every cycle's display.
module tb_stopwatch_ctrl;

  typedef logic [21:0] obs_t;

  localparam int LIMIT   = 6000 * 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic clk;
  logic areset_n;
  logic ss, lp, cl;

  logic [6:0] a_cs, b_cs;
  logic [5:0] a_sec, b_sec, a_min, b_min;
  logic       a_run, b_run, a_lap, b_lap, a_ovf, b_ovf;

  obs_t obs_a, obs_b, exp_a_r, exp_b_r;
  obs_t q_a[$];
  obs_t q_b[$];

  int total;
  int bad;

  int prescale[2];
  int mode[2];
  int phase[2];
  int tcount[2];
  int lapt[2];

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_MOD(2)) dut_a (
    .clk(clk), .areset_n(areset_n), .i_start_stop(ss), .i_lap(lp), .i_clear(cl),
    .o_cs(a_cs), .o_sec(a_sec), .o_min(a_min),
    .o_running(a_run), .o_lapped(a_lap), .o_overflow(a_ovf)
  );

  stopwatch_ctrl #(.CLK_HZ(200), .TICK_HZ(100), .MIN_MOD(2)) dut_b (
    .clk(clk), .areset_n(areset_n), .i_start_stop(ss), .i_lap(lp), .i_clear(cl),
    .o_cs(b_cs), .o_sec(b_sec), .o_min(b_min),
    .o_running(b_run), .o_lapped(b_lap), .o_overflow(b_ovf)
  );

  assign obs_a = {a_min, a_sec, a_cs, a_run, a_lap, a_ovf};
  assign obs_b = {b_min, b_sec, b_cs, b_run, b_lap, b_ovf};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t exp_of(input int i);
    int shown, c, cs, sec, mn;
    bit run, lapd, ovf;
    shown = (mode[i] == M_LAP) ? lapt[i] : tcount[i];
    c     = shown % LIMIT;
    cs    = c % 100;
    sec   = (c / 100) % 60;
    mn    = c / 6000;
    run   = (mode[i] == M_RUN) || (mode[i] == M_LAP);
    lapd  = (mode[i] == M_LAP);
    ovf   = (tcount[i] >= LIMIT);
    return {6'(mn), 6'(sec), 7'(cs), run, lapd, ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; phase[i] = 0; tcount[i] = 0; lapt[i] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit l, input bit c);
    for (int i = 0; i < 2; i++) begin
      if (mode[i] == M_RUN || mode[i] == M_LAP) begin
        phase[i]++;
        if (phase[i] == prescale[i]) begin
          phase[i] = 0;
          tcount[i]++;
        end
      end
      case (mode[i])
        M_IDLE:  if (s) begin mode[i] = M_RUN; phase[i] = 0; end
        M_RUN:   if (s) mode[i] = M_PAUSE;
                 else if (l) begin mode[i] = M_LAP; lapt[i] = tcount[i]; end
        M_LAP:   if (s) mode[i] = M_PAUSE;
                 else if (l) mode[i] = M_RUN;
        M_PAUSE: if (c) begin mode[i] = M_IDLE; tcount[i] = 0; phase[i] = 0; end
                 else if (s) mode[i] = M_RUN;
        default: mode[i] = M_IDLE;
      endcase
    end
  endtask

  task automatic cycle(input bit s, input bit l, input bit c);
    ss = s; lp = l; cl = c;
    @(posedge clk);
    model_step(s, l, c);
    q_a.push_back(exp_of(0));
    q_b.push_back(exp_of(1));
    #1;
    ss = 1'b0; lp = 1'b0; cl = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_cs"}, a_cs, 0);   chk({tag, "_a_sec"}, a_sec, 0);
    chk({tag, "_a_min"}, a_min, 0); chk({tag, "_a_run"}, a_run, 0);
    chk({tag, "_a_lap"}, a_lap, 0); chk({tag, "_a_ovf"}, a_ovf, 0);
    chk({tag, "_b_cs"}, b_cs, 0);   chk({tag, "_b_run"}, b_run, 0);
    chk({tag, "_b_ovf"}, b_ovf, 0);
  endtask

  // Asynchronous reset between edges: outputs must drop before any clock edge.
  task automatic do_reset();
    #1 areset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    q_a.delete();
    q_b.delete();
    model_reset();
    #1 areset_n = 1'b1;
  endtask

  // Monitor: every cycle the DUTs present a display word; compare against the queue.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_a_r = q_a.pop_front();
      total++;
      if (obs_a !== exp_a_r) begin
        bad++;
        $display("FAIL sb_a @%0t: got %h expected %h", $time, obs_a, exp_a_r);
      end
    end
    if (q_b.size() > 0) begin
      exp_b_r = q_b.pop_front();
      total++;
      if (obs_b !== exp_b_r) begin
        bad++;
        $display("FAIL sb_b @%0t: got %h expected %h", $time, obs_b, exp_b_r);
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    prescale[0] = 10; prescale[1] = 2;
    model_reset();
    ss = 1'b0; lp = 1'b0; cl = 1'b0;
    areset_n = 1'b0;
    #12 chk_all_zero("por");
    #4 areset_n = 1'b1;

    // Reset mid-run
    cycle(1'b1, 1'b0, 1'b0);
    idle(37);
    do_reset();

    // Basic run and first-tick latency
    cycle(1'b1, 1'b0, 1'b0);
    idle(9);
    chk("first_tick_early", a_cs, 0);
    idle(1);
    chk("first_tick", a_cs, 1);
    idle(990);
    chk("run_sec", a_sec, 1);
    chk("run_cs", a_cs, 0);
    chk("run_running", a_run, 1);

    // Pause with partial prescale, then resume
    idle(253);
    cycle(1'b1, 1'b0, 1'b0);
    chk("pause_cs", a_cs, 25);
    chk("pause_running", a_run, 0);
    idle(500);
    chk("pause_hold_cs", a_cs, 25);
    cycle(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("resume_early", a_cs, 25);
    idle(1);
    chk("resume_cs", a_cs, 26);

    // Lap freeze and release
    idle(239);
    cycle(1'b0, 1'b1, 1'b0);
    chk("lap_min", a_min, 0);
    chk("lap_sec", a_sec, 1);
    chk("lap_cs", a_cs, 50);
    chk("lap_flag", a_lap, 1);
    idle(150);
    chk("lap_frozen_cs", a_cs, 50);
    idle(149);
    cycle(1'b0, 1'b1, 1'b0);
    chk("unlap_sec", a_sec, 1);
    chk("unlap_cs", a_cs, 80);
    chk("unlap_flag", a_lap, 0);

    // Clear rules
    cycle(1'b0, 1'b0, 1'b1);
    chk("clr_in_run", a_run, 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk_all_zero("clr_pause");

    // Overflow on the fast instance: 12000 ticks wraps 1:59.99 -> 0:00.00
    cycle(1'b1, 1'b0, 1'b0);
    idle(24000);
    chk("ovf_b_cs", b_cs, 0);
    chk("ovf_b_sec", b_sec, 0);
    chk("ovf_b_min", b_min, 0);
    chk("ovf_b_flag", b_ovf, 1);
    idle(100);
    chk("ovf_b_sticky", b_ovf, 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("ovf_b_cleared", b_ovf, 0);

    // Random command pulses
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        cycle(r < 4, (r >= 4) && (r < 8), ((r >= 8) && (r < 12)) || (r == 0));
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
